// File: rtl/resp_cap_pkg.sv
// Shared types and defaults for the response MISR capture stage.
// resp_misr_capture honours `RESP_XMASK_EN (per-bit response masking).
package resp_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int              RESP_W_DEFAULT = 8;
    localparam int              SIG_W_DEFAULT  = 16;
    localparam int              CNT_W_DEFAULT  = 16;
    localparam logic [15:0]     POLY_DEFAULT   = 16'h1021;
    localparam logic [15:0]     SEED_DEFAULT   = 16'hFFFF;

    // One MISR step at the default widths and polynomial.
    function automatic logic [SIG_W_DEFAULT-1:0] misr_step(
        input logic [SIG_W_DEFAULT-1:0]  sig,
        input logic [RESP_W_DEFAULT-1:0] data
    );
        logic [SIG_W_DEFAULT-1:0] shifted;
        shifted = {sig[SIG_W_DEFAULT-2:0], 1'b0};
        if (sig[SIG_W_DEFAULT-1]) begin
            shifted = shifted ^ POLY_DEFAULT;
        end
        return shifted ^ SIG_W_DEFAULT'(data);
    endfunction

endpackage

// File: rtl/resp_misr_capture_misr_reg.sv
// Galois MISR: loads a seed, then folds one response vector per enabled cycle.
module misr_reg #(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = 8,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              en,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            sig_next = sig_next ^ POLY;
        end
        sig_next = sig_next ^ SIG_W'(data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/resp_misr_capture.sv
// Response capture: compacts num_patterns beats into a MISR and checks the result.
// Define RESP_XMASK_EN to add the resp_mask port (masked bits are compacted as 0).
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting and compacting beats
//   CHECK | one cycle, comparing signature with the latched golden value
//   DONE  | verdict held on pass; start re-arms
module resp_misr_capture
    import resp_cap_pkg::*;
#(
    parameter int               RESP_W = 8,
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = POLY_DEFAULT,
    parameter logic [SIG_W-1:0] SEED   = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  exp_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  beat_cnt
`ifdef RESP_XMASK_EN
    ,
    input  logic [RESP_W-1:0] resp_mask
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  target;
    logic [SIG_W-1:0]  exp_lat;
    logic              pass_r;
    logic              arm;
    logic              take;
    logic              last_beat;
    logic [RESP_W-1:0] misr_data;

`ifdef RESP_XMASK_EN
    assign misr_data = resp_data & ~resp_mask;
`else
    assign misr_data = resp_data;
`endif

    // Handshake outputs come from the state register only.
    assign resp_ready = (state == RUN);
    assign busy       = (state == RUN) || (state == CHECK);
    assign done       = (state == DONE);
    assign pass       = pass_r;

    assign arm       = start && !abort && ((state == IDLE) || (state == DONE));
    assign take      = resp_ready && resp_valid && !abort;
    assign last_beat = ((beat_cnt + CNT_ONE) == target);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = (num_patterns == '0) ? CHECK : RUN;
                    end
                end
                RUN: begin
                    if (take && last_beat) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK:   state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort leaves signature and beat_cnt untouched so a cancelled run can be inspected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            target   <= '0;
            exp_lat  <= '0;
            pass_r   <= 1'b0;
        end else begin
            if (arm) begin
                beat_cnt <= '0;
                target   <= num_patterns;
                exp_lat  <= exp_sig;
            end else if (take) begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end

            if (abort || arm) begin
                pass_r <= 1'b0;
            end else if (state == CHECK) begin
                pass_r <= (signature == exp_lat);
            end
        end
    end

    misr_reg #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (arm),
        .seed  (SEED),
        .en    (take),
        .data  (misr_data),
        .sig   (signature)
    );

endmodule

// File: tb/tb_resp_misr_capture.sv
// Randomized self-checking bench for resp_misr_capture; two instances (seed FFFF and seed 0).
module tb_resp_misr_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_patterns;
    logic [15:0] exp_sig;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [7:0]  mask_v = 8'h00;

    logic        ready_a, busy_a, done_a, pass_a;
    logic [15:0] sig_a, cnt_a;
    logic        ready_b, busy_b, done_b, pass_b;
    logic [15:0] sig_b, cnt_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] beat_q[$];
    int         gap_q[$];

    always #5 clk = ~clk;

    resp_misr_capture #(.SEED(16'hFFFF)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_patterns(num_patterns), .exp_sig(exp_sig),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(ready_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .beat_cnt(cnt_a)
`ifdef RESP_XMASK_EN
        , .resp_mask(mask_v)
`endif
    );

    resp_misr_capture #(.SEED(16'h0000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_patterns(num_patterns), .exp_sig(exp_sig),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(ready_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .beat_cnt(cnt_b)
`ifdef RESP_XMASK_EN
        , .resp_mask(mask_v)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signature as polynomial arithmetic, multiply by x modulo x^16+POLY, add data.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [7:0] d);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 32'h10000) v = v ^ 32'h11021;
        return v[15:0] ^ {8'h00, d & ~mask_v};
    endfunction

    function automatic logic [15:0] ref_sig(input logic [15:0] seed, input int upto);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < upto; i++) s = ref_step(s, beat_q[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {ready_a, ready_b}, 2'b00);
        check({tag, "_busy"},  {busy_a, busy_b}, 2'b00);
        check({tag, "_done"},  {done_a, done_b}, 2'b00);
        check({tag, "_pass"},  {pass_a, pass_b}, 2'b00);
        check({tag, "_sig"},   {sig_a, sig_b}, {16'hFFFF, 16'h0000});
        check({tag, "_cnt"},   {cnt_a, cnt_b}, 32'h0);
    endtask

    // Full run over beat_q with per-beat gaps from gap_q; noise pulses start during gaps.
    task automatic run_case(input string tag, input int n, input logic [15:0] e, input bit noise);
        logic [15:0] ma, mb;
        ma = ref_sig(16'hFFFF, n);
        mb = ref_sig(16'h0000, n);
        start = 1'b1; num_patterns = 16'(n); exp_sig = e;
        tick();
        start = 1'b0;
        num_patterns = 16'($urandom);
        exp_sig = 16'($urandom);
        if (n == 0) begin
            check({tag, "_zero_busy"}, {busy_a, ready_a}, 2'b10);
        end else begin
            check({tag, "_start_lat"}, {ready_a, ready_b, busy_a}, 3'b111);
            check({tag, "_seed_load"}, {sig_a, sig_b, cnt_a}, {16'hFFFF, 16'h0000, 16'h0000});
            for (int i = 0; i < n; i++) begin
                int g;
                g = (i < gap_q.size()) ? gap_q[i] : 0;
                for (int k = 0; k < g; k++) begin
                    resp_valid = 1'b0;
                    resp_data  = 8'($urandom);
                    if (noise && ($urandom_range(0, 1) == 1)) begin
                        start = 1'b1;
                        num_patterns = 16'($urandom_range(0, 3));
                    end
                    tick();
                    start = 1'b0;
                end
                resp_valid = 1'b1;
                resp_data  = beat_q[i];
                tick();
            end
            resp_valid = 1'b0;
            check({tag, "_check_state"}, {busy_a, done_a, ready_a}, 3'b100);
        end
        tick();
        check({tag, "_done"}, {done_a, done_b, busy_a}, 3'b110);
        check({tag, "_sig"}, {sig_a, sig_b}, {ma, mb});
        check({tag, "_pass"}, {pass_a, pass_b}, {ma == e, mb == e});
        if (n != 0) check({tag, "_cnt"}, {cnt_a, cnt_b}, {16'(n), 16'(n)});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        num_patterns = '0; exp_sig = '0; resp_valid = 1'b0; resp_data = '0;
        tick(); tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single beat 00: FFFF -> EFDF.
        beat_q = '{8'h00}; gap_q = '{};
        run_case("single", 1, 16'hEFDF, 1'b0);
        check("single_known", sig_a, 16'hEFDF);

        // Two beats 01,01 from seed 0 -> 0003, then wrong golden.
        beat_q = '{8'h01, 8'h01}; gap_q = '{};
        run_case("two_ok", 2, 16'h0003, 1'b0);
        check("two_known", sig_b, 16'h0003);
        run_case("two_bad", 2, 16'h0004, 1'b0);

        // Backpressure gaps match the gapless signature.
        beat_q = '{8'hA5, 8'h3C, 8'hF0}; gap_q = '{};
        run_case("gapless", 3, 16'h1234, 1'b0);
        gap_q = '{0, 2, 5};
        run_case("gaps", 3, ref_sig(16'hFFFF, 3), 1'b1);

        // Zero patterns: verdict straight from the seed.
        run_case("zero", 0, 16'hFFFF, 1'b0);
        run_case("zero_b", 0, 16'h0000, 1'b0);

        // Abort after 2 of 4 beats, with a beat offered in the abort cycle.
        beat_q = '{8'h11, 8'h22, 8'h33, 8'h44}; gap_q = '{};
        start = 1'b1; num_patterns = 16'd4; exp_sig = 16'h0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1; resp_data = beat_q[i];
            tick();
        end
        abort = 1'b1; start = 1'b1; resp_data = beat_q[2];
        tick();
        abort = 1'b0; start = 1'b0; resp_valid = 1'b0;
        check("abort_state", {busy_a, done_a, ready_a, pass_a}, 4'b0000);
        check("abort_sig_hold", {sig_a, sig_b}, {ref_sig(16'hFFFF, 2), ref_sig(16'h0000, 2)});
        check("abort_cnt_hold", cnt_a, 16'd2);
        tick();
        check("abort_idle_stays", {busy_a, done_a}, 2'b00);
        run_case("after_abort", 4, ref_sig(16'h0000, 4), 1'b0);

        // Abort from DONE clears done and pass.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", {done_b, pass_b}, 2'b00);

        // Reset mid-run: beat in the reset cycle dropped, everything back to reset values.
        start = 1'b1; num_patterns = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1; resp_data = beat_q[i];
            tick();
        end
        rst_n = 1'b0;
        tick();
        resp_valid = 1'b0;
        check_reset_vals("midrst");
        rst_n = 1'b1;
        tick();

`ifdef RESP_XMASK_EN
        mask_v = 8'hFF;
        beat_q = '{8'($urandom)}; gap_q = '{};
        run_case("mask", 1, 16'h0000, 1'b0);
        check("mask_zero", sig_b, 16'h0000);
        mask_v = 8'h00;
`endif

        // Randomized runs, restarting from DONE each time.
        for (int r = 0; r < 25; r++) begin
            int n;
            logic [15:0] e;
            n = $urandom_range(1, 12);
            beat_q = '{}; gap_q = '{};
            for (int i = 0; i < n; i++) begin
                beat_q.push_back(8'($urandom));
                gap_q.push_back($urandom_range(0, 3));
            end
            e = ref_sig(16'hFFFF, n);
            if ($urandom_range(0, 2) == 0) e = e ^ 16'(1 << $urandom_range(0, 15));
            run_case("rand", n, e, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
